arith_result_stage: RTL and testbench
=====================================

Name: arith_result_stage

Overview:
- Registered output stage directly downstream of the combinational 8-bit add/sub/mul/div unit.
- Per transaction it:
  - selects one of the four results by opcode;
  - computes status flags;
  - sanitises divide-by-zero;
  - buffers the result in a small FIFO behind a valid/ready handshake, so the unit's outputs reach a stallable consumer.
- Also keeps saturating event counters for debug.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, ≥2)
- CNT_W, 8, width of each saturating event counter
- DZ_VALUE, 8'hFF, result substituted on divide by zero

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_valid  in  1  upstream operands/results valid this cycle
- o_ready  out  1  stage can accept (FIFO not full)
- i_op  in  2  opcode: 0 add, 1 sub, 2 mul, 3 div
- i_value_a  in  8  operand A (same operands fed to arithmetic unit)
- i_value_b  in  8  operand B
- i_result_add  in  8  from arithmetic unit
- i_result_sub  in  8  from arithmetic unit
- i_result_mul  in  8  from arithmetic unit
- i_result_div  in  8  from arithmetic unit
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts head
- o_result  out  8  selected/sanitised result at head
- o_op  out  2  opcode of head entry
- o_flag_carry  out  1  add carry-out / sub borrow / mul overflow; 0 for div
- o_flag_zero  out  1  o_result == 0
- o_flag_dz  out  1  div with B == 0
- o_cnt_txn  out  CNT_W  accepted transactions, saturating
- o_cnt_dz  out  CNT_W  divide-by-zero events, saturating

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values:
  - FIFO empty; o_valid=0.
  - o_result=0, o_op=0, all flags 0, both counters 0.
  - o_ready=1 from the first cycle after reset deasserts.
  - Reset mid-stream discards all buffered entries; no partial output.
- Accept: when i_valid && o_ready, write one entry (result, op, 3 flags) into the FIFO on that edge.
- Emit: when o_valid && i_ready, pop the head on that edge.
- Latency: first-word latency is 1 cycle. An entry accepted at edge N is visible on o_* after edge N with o_valid=1 if the FIFO was empty.
- Result select: result is chosen by i_op from the four inputs. If op=div and B==0, the result becomes DZ_VALUE and dz=1. The unit's raw div output is ignored.
- Carry flag, computed from operands with 9/16-bit internal widths:
  - add: carry = bit 8 of {1'b0,A}+{1'b0,B}.
  - sub: carry = (A<B), i.e. borrow.
  - mul: carry = |(A*B)[15:8].
  - div: carry = 0.
- Zero flag: computed on the stored (post-sanitise) result.
- Outputs o_result/o_op/flags always reflect the FIFO head. When empty, they hold the last popped values; consumers must qualify with o_valid.
- Full: o_ready=0 when count==DEPTH. The ready computation ignores the same-cycle pop: no bypass and no combinational path from i_ready to o_ready. The upstream stalls; the unit's combinational outputs track the held operands.
- Empty: o_valid=0; popping is ignored.
- Simultaneous push and pop, with count neither 0 nor DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count range is 0..DEPTH.
- Counters:
  - o_cnt_txn increments on every accept.
  - o_cnt_dz increments on every accepted div-by-zero.
  - Both saturate at all ones (no wrap).
  - Both are cleared only by reset.
- i_valid while o_ready=0: no write and no counter change. Upstream must hold its data.

Decomposition:
- Shared include "arith_defs":
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - entry width constant (8 result + 2 op + 3 flags = 13).
- Sub-module arith_sync_fifo (parameters WIDTH, DEPTH): synchronous-reset circular buffer with count, full, empty, push and pop. The top level holds select/flag logic and the counters.

Test Plan:
- Reset then single add A=200, B=100 (add result 44), i_ready=1 -> one cycle later o_valid=1, o_result=44, carry=1, zero=0, dz=0; o_cnt_txn=1.
- Div A=50, B=0 -> o_result=8'hFF, dz=1, carry=0; o_cnt_dz=1. Then div A=50, B=7 -> o_result=7, dz=0.
- Sub A=5, B=5 -> o_result=0, zero=1, carry=0. Sub A=3, B=4 -> o_result=255, carry=1. Mul A=16, B=16 -> o_result=0, carry=1, zero=1.
- Hold i_ready=0 and push 5 ops with DEPTH=4 -> o_ready drops after the 4th accept, the 5th is not accepted and o_cnt_txn=4. Release i_ready -> 4 results drain in order, then the 5th is accepted.
- Continuous i_valid and i_ready for 20 cycles -> one result per cycle, order preserved, count stays ≤1; o_cnt_txn=20.
- Assert i_rst with 3 entries buffered -> next cycle o_valid=0, counters 0, o_ready=1; nothing from before the reset is ever emitted.
- Counter saturation with CNT_W=2: push 5 div-by-zero ops -> o_cnt_dz=3 and o_cnt_txn=3, both holding at 3.

Source files
------------

// File: rtl/arith_result_stage_pkg.sv
// rtl/arith_result_stage_pkg.sv - shared opcodes and FIFO entry layout for the arithmetic result stage
package arith_result_stage_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   localparam int ENTRY_W = 13;

   typedef struct packed {
      logic [7:0] result;
      logic [1:0] op;
      logic       carry;
      logic       zero;
      logic       dz;
   } entry_t;

endpackage

// File: rtl/arith_sync_fifo.sv
// rtl/arith_sync_fifo.sv - synchronous-reset circular buffer with count/full/empty
// When empty, o_data holds the most recently popped entry rather than stale memory.
module arith_sync_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] last_pop;
   logic             push_en;
   logic             pop_en;

   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;
   assign push_en = i_push && !o_full;
   assign pop_en  = i_pop && !o_empty;
   assign o_data  = o_empty ? last_pop : mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push_en) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_pop <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_pop <= mem[rd_ptr];
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arith_result_stage.sv
// rtl/arith_result_stage.sv - result select, flags, divide-by-zero sanitising and buffered handshake
module arith_result_stage
   import arith_result_stage_pkg::*;
#(
   parameter int         DEPTH    = 4,
   parameter int         CNT_W    = 8,
   parameter logic [7:0] DZ_VALUE = 8'hFF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_op,
   input  logic [7:0]       i_value_a,
   input  logic [7:0]       i_value_b,
   input  logic [7:0]       i_result_add,
   input  logic [7:0]       i_result_sub,
   input  logic [7:0]       i_result_mul,
   input  logic [7:0]       i_result_div,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [7:0]       o_result,
   output logic [1:0]       o_op,
   output logic             o_flag_carry,
   output logic             o_flag_zero,
   output logic             o_flag_dz,
   output logic [CNT_W-1:0] o_cnt_txn,
   output logic [CNT_W-1:0] o_cnt_dz
);

   logic [8:0]          sum9;
   logic [15:0]         prod16;
   entry_t              new_entry;
   entry_t              head;
   logic                full;
   logic                empty;
   logic                accept;
   logic [$clog2(DEPTH):0] count_unused;

   assign sum9   = {1'b0, i_value_a} + {1'b0, i_value_b};
   assign prod16 = 16'(i_value_a) * 16'(i_value_b);

   // Flags come from the operands, not the unit's truncated results.
   always_comb begin
      new_entry        = '0;
      new_entry.op     = i_op;
      new_entry.result = i_result_add;
      case (i_op)
         OP_ADD: begin
            new_entry.result = i_result_add;
            new_entry.carry  = sum9[8];
         end
         OP_SUB: begin
            new_entry.result = i_result_sub;
            new_entry.carry  = (i_value_a < i_value_b);
         end
         OP_MUL: begin
            new_entry.result = i_result_mul;
            new_entry.carry  = |prod16[15:8];
         end
         default: begin
            new_entry.dz     = (i_value_b == 8'd0);
            new_entry.result = new_entry.dz ? DZ_VALUE : i_result_div;
         end
      endcase
      new_entry.zero = (new_entry.result == 8'd0);
   end

   arith_sync_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_push (i_valid),
      .i_pop  (i_ready),
      .i_data (new_entry),
      .o_data (head),
      .o_full (full),
      .o_empty(empty),
      .o_count(count_unused)
   );

   assign o_ready      = !full;
   assign o_valid      = !empty;
   assign accept       = i_valid && o_ready;
   assign o_result     = head.result;
   assign o_op         = head.op;
   assign o_flag_carry = head.carry;
   assign o_flag_zero  = head.zero;
   assign o_flag_dz    = head.dz;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cnt_txn <= '0;
         o_cnt_dz  <= '0;
      end else if (accept) begin
         if (o_cnt_txn != '1) begin
            o_cnt_txn <= o_cnt_txn + 1'b1;
         end
         if (new_entry.dz && (o_cnt_dz != '1)) begin
            o_cnt_dz <= o_cnt_dz + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arith_result_stage.sv
// tb/tb_arith_result_stage.sv - randomized and directed check of arith_result_stage against a queue model
module tb_arith_result_stage;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic       rdy;
   logic [1:0] op;
   logic [7:0] a, b;
   logic [7:0] r_add, r_sub, r_mul, r_div;

   logic       o_ready, o_valid, fc, fz, fd;
   logic [1:0] o_op;
   logic [7:0] o_result, cnt_txn, cnt_dz;

   logic       s_ready, s_valid, s_fc, s_fz, s_fd;
   logic [1:0] s_op;
   logic [7:0] s_result;
   logic [1:0] s_cnt_txn, s_cnt_dz;

   typedef struct {
      int res;
      int op;
      int c;
      int z;
      int d;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   m_txn, m_dz, m_txn_s, m_dz_s;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   arith_result_stage #(.DEPTH(DEPTH), .CNT_W(8), .DZ_VALUE(8'hFF)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_op(op),
      .i_value_a(a), .i_value_b(b), .i_result_add(r_add), .i_result_sub(r_sub),
      .i_result_mul(r_mul), .i_result_div(r_div), .o_valid(o_valid), .i_ready(rdy),
      .o_result(o_result), .o_op(o_op), .o_flag_carry(fc), .o_flag_zero(fz),
      .o_flag_dz(fd), .o_cnt_txn(cnt_txn), .o_cnt_dz(cnt_dz)
   );

   arith_result_stage #(.DEPTH(DEPTH), .CNT_W(2), .DZ_VALUE(8'hFF)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(s_ready), .i_op(op),
      .i_value_a(a), .i_value_b(b), .i_result_add(r_add), .i_result_sub(r_sub),
      .i_result_mul(r_mul), .i_result_div(r_div), .o_valid(s_valid), .i_ready(rdy),
      .o_result(s_result), .o_op(s_op), .o_flag_carry(s_fc), .o_flag_zero(s_fz),
      .o_flag_dz(s_fd), .o_cnt_txn(s_cnt_txn), .o_cnt_dz(s_cnt_dz)
   );

   function automatic exp_t ref_entry(int opc, int av, int bv);
      exp_t e;
      e.op = opc;
      e.c  = 0;
      e.d  = 0;
      case (opc)
         0: begin e.res = (av + bv) % 256;       e.c = ((av + bv) > 255); end
         1: begin e.res = (av - bv + 256) % 256; e.c = (av < bv);         end
         2: begin e.res = (av * bv) % 256;       e.c = ((av * bv) > 255); end
         default: begin
            if (bv == 0) begin e.res = 255; e.d = 1; end
            else         e.res = av / bv;
         end
      endcase
      e.z = (e.res == 0);
      return e;
   endfunction

   function automatic int sat_inc(int v, int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      exp_t h;
      h = (q.size() > 0) ? q[0] : last;
      chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
      chk("o_ready", 32'(o_ready), 32'(q.size() < DEPTH));
      chk("o_result", 32'(o_result), 32'(h.res));
      chk("o_op", 32'(o_op), 32'(h.op));
      chk("carry", 32'(fc), 32'(h.c));
      chk("zero", 32'(fz), 32'(h.z));
      chk("dz", 32'(fd), 32'(h.d));
      chk("cnt_txn", 32'(cnt_txn), 32'(m_txn));
      chk("cnt_dz", 32'(cnt_dz), 32'(m_dz));
      chk("sat_cnt_txn", 32'(s_cnt_txn), 32'(m_txn_s));
      chk("sat_cnt_dz", 32'(s_cnt_dz), 32'(m_dz_s));
      chk("sat_result", 32'(s_result), 32'(h.res));
   endtask

   task automatic step(input bit v, input int opc, input int av, input int bv, input bit r);
      bit   acc, pop;
      exp_t e;
      valid = v;
      op    = 2'(opc);
      a     = 8'(av);
      b     = 8'(bv);
      r_add = 8'(av + bv);
      r_sub = 8'(av - bv);
      r_mul = 8'(av * bv);
      r_div = (bv != 0) ? 8'(av / bv) : 8'($urandom);
      rdy   = r;
      acc   = v && (q.size() < DEPTH);
      pop   = r && (q.size() > 0);
      @(posedge clk);
      #1;
      if (pop) last = q.pop_front();
      if (acc) begin
         e = ref_entry(opc, av, bv);
         q.push_back(e);
         m_txn   = sat_inc(m_txn, 255);
         m_txn_s = sat_inc(m_txn_s, 3);
         if (e.d != 0) begin
            m_dz   = sat_inc(m_dz, 255);
            m_dz_s = sat_inc(m_dz_s, 3);
         end
      end
      check_all();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      last    = '{0, 0, 0, 0, 0};
      m_txn   = 0;
      m_dz    = 0;
      m_txn_s = 0;
      m_dz_s  = 0;
      check_all();
   endtask

   initial begin
      int a5, b5;
      rst = 1'b1; valid = 1'b0; rdy = 1'b0; op = '0; a = '0; b = '0;
      r_add = '0; r_sub = '0; r_mul = '0; r_div = '0;
      do_reset();

      step(1, 0, 200, 100, 1);
      chk("add_result_44", 32'(o_result), 32'd44);
      chk("add_carry", 32'(fc), 32'd1);
      chk("add_txn_1", 32'(cnt_txn), 32'd1);
      step(1, 3, 50, 0, 1);
      chk("div0_result", 32'(o_result), 32'hFF);
      chk("div0_cnt", 32'(cnt_dz), 32'd1);
      step(1, 3, 50, 7, 1);
      chk("div_result_7", 32'(o_result), 32'd7);
      step(1, 1, 5, 5, 1);
      step(1, 1, 3, 4, 1);
      chk("sub_borrow_255", 32'(o_result), 32'd255);
      step(1, 2, 16, 16, 1);
      chk("mul_ovf_zero", 32'({fc, fz}), 32'b11);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      do_reset();
      for (int i = 0; i < 4; i++) step(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      a5 = $urandom_range(0, 255);
      b5 = $urandom_range(0, 255);
      step(1, 0, a5, b5, 0);
      chk("stall_txn_4", 32'(cnt_txn), 32'd4);
      for (int i = 0; i < 3; i++) step(1, 0, a5, b5, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

      do_reset();
      for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1);
      chk("stream_txn_20", 32'(cnt_txn), 32'd20);
      step(0, 0, 0, 0, 1);

      for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

      for (int i = 0; i < 5; i++) step(1, 3, $urandom_range(0, 255), 0, 1);
      chk("sat_dz_3", 32'(s_cnt_dz), 32'd3);
      chk("sat_txn_3", 32'(s_cnt_txn), 32'd3);

      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255), $urandom_range(0, 2) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
